// File: rtl/adpll_seq_if.sv
// ============================================================================
// Module   : adpll_seq_if
// Purpose  : ADPLL register bus (valid/address/wdata/wstrb/rdata/ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adpll_seq_if #(
    parameter int ADDR_W = 5
);
    logic              m_valid;
    logic [ADDR_W-1:0] m_address;
    logic [31:0]       m_wdata;
    logic              m_wstrb;
    logic [31:0]       m_rdata;
    logic              m_ready;

    modport master (
        output m_valid, m_address, m_wdata, m_wstrb,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_address, m_wdata, m_wstrb,
        output m_rdata, m_ready
    );
endinterface

`default_nettype wire

// File: rtl/adpll_seq.sv
// ============================================================================
// Module   : adpll_seq
// Purpose  : ADPLL bring-up/retune sequencer: reset, FCW, mode, enable, then
//            settle and poll for lock with timeout; abortable at any point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adpll_seq #(
    parameter int ADDR_W      = 5,
    parameter int FCWW        = 26,
    parameter int A_SOFT_RST  = 0,
    parameter int A_FCW       = 1,
    parameter int A_MODE      = 2,
    parameter int A_EN        = 3,
    parameter int A_LOCK      = 4,
    parameter int SETTLE_CYC  = 256,
    parameter int LOCK_CONF   = 4,
    parameter int TIMEOUT_CYC = 65536,
    parameter int CNT_W       = 17
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            start_i,
    input  wire logic            abort_i,
    input  wire logic [FCWW-1:0] fcw_in_i,
    input  wire logic [1:0]      mode_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 locked_o,
    output logic                 timeout_o,
    adpll_seq_if.master          bus
);

    localparam int CONF_W = $clog2(LOCK_CONF + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_W_SRST = 4'd1,
        S_W_FCW  = 4'd2,
        S_W_MODE = 4'd3,
        S_W_EN   = 4'd4,
        S_SETTLE = 4'd5,
        S_POLL   = 4'd6,
        S_W_DIS  = 4'd7,
        S_FIN    = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic                wait_q, wait_d;
    logic                abort_q, abort_d;
    logic [FCWW-1:0]     fcw_q, fcw_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CONF_W-1:0]   conf_q, conf_d;
    logic                locked_q, locked_d;
    logic                timeout_q, timeout_d;

    logic                w_is_bus;
    logic                w_acc_done;
    logic                w_abort_now;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CONF_W-1:0]   w_conf_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 1'b0;
            abort_q   <= 1'b0;
            fcw_q     <= '0;
            mode_q    <= '0;
            cnt_q     <= '0;
            conf_q    <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            abort_q   <= abort_d;
            fcw_q     <= fcw_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            conf_q    <= conf_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    // Bus fields follow the state directly, so they stay put until m_ready.
    always_comb begin
        w_is_bus      = (state_q == S_W_SRST) || (state_q == S_W_FCW) ||
                        (state_q == S_W_MODE) || (state_q == S_W_EN)  ||
                        (state_q == S_POLL)   || (state_q == S_W_DIS);
        bus.m_valid   = w_is_bus && !wait_q;
        bus.m_address = '0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = 1'b0;
        case (state_q)
            S_W_SRST: begin
                bus.m_address = ADDR_W'(A_SOFT_RST);
                bus.m_wdata   = 32'd1;
                bus.m_wstrb   = 1'b1;
            end
            S_W_FCW: begin
                bus.m_address = ADDR_W'(A_FCW);
                bus.m_wdata   = 32'(fcw_q);
                bus.m_wstrb   = 1'b1;
            end
            S_W_MODE: begin
                bus.m_address = ADDR_W'(A_MODE);
                bus.m_wdata   = 32'(mode_q);
                bus.m_wstrb   = 1'b1;
            end
            S_W_EN: begin
                bus.m_address = ADDR_W'(A_EN);
                bus.m_wdata   = 32'd1;
                bus.m_wstrb   = 1'b1;
            end
            S_POLL: begin
                bus.m_address = ADDR_W'(A_LOCK);
            end
            S_W_DIS: begin
                bus.m_address = ADDR_W'(A_EN);
                bus.m_wstrb   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        abort_d     = abort_q;
        fcw_d       = fcw_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        conf_d      = conf_q;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        w_acc_done  = w_is_bus && wait_q && bus.m_ready;
        w_abort_now = abort_q || abort_i;
        w_cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        w_conf_next = bus.m_rdata[0] ? conf_q + CONF_W'(1) : '0;

        if (w_is_bus) begin
            if (!wait_q) begin
                wait_d = 1'b1;
            end else if (bus.m_ready) begin
                wait_d = 1'b0;
            end
        end

        // Abort during an access is remembered and honoured once it completes.
        if (abort_i && w_is_bus && (state_q != S_W_DIS)) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    fcw_d     = fcw_in_i;
                    mode_d    = mode_in_i;
                    locked_d  = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    conf_d    = '0;
                    state_d   = S_W_SRST;
                end
            end
            S_W_SRST: if (w_acc_done) state_d = w_abort_now ? S_W_DIS : S_W_FCW;
            S_W_FCW:  if (w_acc_done) state_d = w_abort_now ? S_W_DIS : S_W_MODE;
            S_W_MODE: if (w_acc_done) state_d = w_abort_now ? S_W_DIS : S_W_EN;
            S_W_EN: begin
                if (w_acc_done) begin
                    cnt_d   = '0;
                    conf_d  = '0;
                    state_d = w_abort_now ? S_W_DIS : S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = w_cnt_inc;
                if (abort_i) begin
                    state_d = S_W_DIS;
                end else if (w_cnt_inc == CNT_W'(SETTLE_CYC)) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                cnt_d = w_cnt_inc;
                if (w_acc_done) begin
                    conf_d = w_conf_next;
                    if (w_abort_now) begin
                        state_d = S_W_DIS;
                    end else if (w_conf_next == CONF_W'(LOCK_CONF)) begin
                        locked_d = 1'b1;
                        state_d  = S_FIN;
                    end else if (cnt_q >= CNT_W'(TIMEOUT_CYC)) begin
                        timeout_d = 1'b1;
                        state_d   = S_W_DIS;
                    end
                end
            end
            S_W_DIS:  if (w_acc_done) state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_FIN);
    assign locked_o  = locked_q;
    assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_adpll_seq.sv
// ============================================================================
// Module   : tb_adpll_seq
// Purpose  : Self-checking bench for adpll_seq with a bus responder and a
//            time-based sequence model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adpll_seq;

    localparam int SETTLE  = 256;
    localparam int CONF    = 4;
    localparam int TIMEOUT = 1024;

    typedef struct {
        int          a;
        logic [31:0] d;
        logic        w;
        int          tv;
        int          tr;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [25:0] fcw = '0;
    logic [1:0]  mode = '0;
    logic        busy, done, locked, timeout;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   extra_dly = 0;
    int   rsp_idx = 0;
    bit   pat[$];
    bit   lock_dflt = 1'b1;
    txn_t txq[$];
    txn_t expq[$];

    adpll_seq_if #(.ADDR_W(5)) bus ();

    adpll_seq #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .abort_i   (abort),
        .fcw_in_i  (fcw),
        .mode_in_i (mode),
        .busy_o    (busy),
        .done_o    (done),
        .locked_o  (locked),
        .timeout_o (timeout),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Bus responder: acknowledges after 1+extra_dly cycles and logs accesses.
    initial begin : responder
        txn_t        cur;
        bit          pend;
        int          wcnt;
        logic [31:0] rnd;
        bit          b;
        pend = 1'b0;
        wcnt = 0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.m_ready = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                chk("valid_while_waiting", 64'(bus.m_valid), 64'd0);
                chk("addr_hold", 64'(bus.m_address), 64'(cur.a));
                chk("wdata_hold", 64'(bus.m_wdata), 64'(cur.d));
                chk("wstrb_hold", 64'(bus.m_wstrb), 64'(cur.w));
                if (wcnt == 0) begin
                    rnd = $urandom();
                    if (cur.a == 4 && !cur.w) begin
                        b = (rsp_idx < pat.size()) ? pat[rsp_idx] : lock_dflt;
                        rsp_idx++;
                    end else begin
                        b = rnd[0];
                    end
                    bus.m_rdata = {rnd[31:1], b};
                    bus.m_ready = 1'b1;
                    cur.tr      = cyc;
                    txq.push_back(cur);
                    pend = 1'b0;
                end else begin
                    wcnt--;
                end
            end else if (bus.m_valid) begin
                cur.a  = int'(bus.m_address);
                cur.d  = bus.m_wdata;
                cur.w  = bus.m_wstrb;
                cur.tv = cyc;
                cur.tr = -1;
                pend   = 1'b1;
                wcnt   = extra_dly;
            end
        end
    end

    task automatic push_exp(input int a, input logic [31:0] d, input logic w, input int tv);
        txn_t e;
        e.a = a; e.d = d; e.w = w; e.tv = tv; e.tr = -1;
        expq.push_back(e);
    endtask

    // Reference: timeline of accesses derived from the sequence rules.
    task automatic build_exp(input int t0, input logic [25:0] f, input logic [1:0] m,
                             input int ab, input int dly, output int e_done,
                             output logic e_lk, output logic e_to);
        logic [31:0] wd[4];
        int  t, tv, tr, t_en, run, pi;
        bit  dis, b;
        expq.delete();
        e_lk = 1'b0; e_to = 1'b0; dis = 1'b0;
        wd = '{32'd1, 32'(f), 32'(m), 32'd1};
        t = t0 + 1; tr = t0; t_en = t0;
        for (int i = 0; i < 4 && !dis; i++) begin
            push_exp(i, wd[i], 1'b1, t);
            tr = t + 1 + dly;
            if (ab >= t && ab <= tr) dis = 1'b1;
            t = tr + 1;
            t_en = tr;
        end
        if (!dis && ab >= t_en + 1 && ab <= t_en + SETTLE) begin
            dis = 1'b1;
            t = ab + 1;
        end
        if (!dis) begin
            t = t_en + SETTLE + 1; run = 0; pi = 0;
            while (1) begin
                tv = t;
                push_exp(4, 32'd0, 1'b0, tv);
                tr = tv + 1 + dly;
                b = (pi < pat.size()) ? pat[pi] : lock_dflt;
                pi++;
                run = b ? run + 1 : 0;
                t = tr + 1;
                if (ab >= tv && ab <= tr) begin dis = 1'b1; break; end
                if (run == CONF) begin e_lk = 1'b1; break; end
                if (tr - t_en - 1 >= TIMEOUT) begin e_to = 1'b1; dis = 1'b1; break; end
            end
        end
        if (dis) begin
            push_exp(3, 32'd0, 1'b1, t);
            t = t + 2 + dly;
        end
        e_done = t;
    endtask

    // One start-to-done sequence; ab_off/bs_off place abort and a busy start.
    task automatic run_seq(input string nm, input logic [25:0] f, input logic [1:0] m,
                           input int ab_off, input int bs_off, input int dly,
                           output int t0, output int tdone, output int polls);
        int   ndone, e_done;
        logic dlk, dto, e_lk, e_to;
        txq.delete();
        rsp_idx   = 0;
        extra_dly = dly;
        fcw = f; mode = m; start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        chk({nm, "_busy_at_start"}, 64'(busy), 64'd1);
        chk({nm, "_locked_cleared"}, 64'(locked), 64'd0);
        chk({nm, "_timeout_cleared"}, 64'(timeout), 64'd0);
        tdone = -1; ndone = 0; dlk = 1'b0; dto = 1'b0;
        for (int k = 0; k < 4000 && (tdone < 0 || cyc < tdone + 4); k++) begin
            abort = (ab_off >= 0 && cyc == t0 + ab_off);
            if (bs_off >= 0 && cyc == t0 + bs_off) begin
                start = 1'b1;
                fcw   = 26'($urandom());
                mode  = 2'($urandom());
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (tdone < 0) begin tdone = cyc; dlk = locked; dto = timeout; end
            end
            tick();
        end
        abort = 1'b0; start = 1'b0;
        build_exp(t0, f, m, (ab_off >= 0) ? t0 + ab_off : -1, dly, e_done, e_lk, e_to);
        chk({nm, "_done_cycle"}, 64'(tdone), 64'(e_done));
        chk({nm, "_done_pulses"}, 64'(ndone), 64'd1);
        chk({nm, "_locked"}, 64'(dlk), 64'(e_lk));
        chk({nm, "_timeout"}, 64'(dto), 64'(e_to));
        chk({nm, "_idle_after"}, 64'(busy), 64'd0);
        chk({nm, "_n_access"}, 64'(txq.size()), 64'(expq.size()));
        polls = 0;
        for (int i = 0; i < txq.size() && i < expq.size(); i++) begin
            chk($sformatf("%s_acc%0d_addr", nm, i), 64'(txq[i].a), 64'(expq[i].a));
            chk($sformatf("%s_acc%0d_wdata", nm, i), 64'(txq[i].d), 64'(expq[i].d));
            chk($sformatf("%s_acc%0d_wstrb", nm, i), 64'(txq[i].w), 64'(expq[i].w));
            chk($sformatf("%s_acc%0d_cycle", nm, i), 64'(txq[i].tv), 64'(expq[i].tv));
        end
        foreach (txq[i]) if (txq[i].a == 4 && !txq[i].w) polls++;
    endtask

    initial begin : main
        int t0, td, np, ab;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_addr", 64'(bus.m_address), 64'd0);
        chk("rst_wdata", 64'(bus.m_wdata), 64'd0);
        chk("rst_wstrb", 64'(bus.m_wstrb), 64'd0);
        rst = 1'b0;
        tick();

        // Immediate lock, with a start pulse while busy that must be ignored.
        pat.delete(); lock_dflt = 1'b1;
        run_seq("lock", 26'h2620000, 2'b01, -1, 2, 0, t0, td, np);
        chk("lock_polls", 64'(np), 64'(CONF));
        chk("lock_latency", 64'(td - t0 + 1), 64'(1 + 8 + SETTLE + 2 * CONF + 1));

        // Confirmation run restarts after a zero read.
        pat = '{1, 1, 0, 1, 1, 1, 1}; lock_dflt = 1'b0;
        run_seq("pat", 26'($urandom()), 2'($urandom()), -1, -1, 0, t0, td, np);
        chk("pat_polls", 64'(np), 64'd7);

        // Lock never seen.
        pat.delete(); lock_dflt = 1'b0;
        run_seq("tmo", 26'($urandom()), 2'($urandom()), -1, -1, 0, t0, td, np);

        // Abort while the FCW write is waiting for ready, then during settle.
        lock_dflt = 1'b1;
        run_seq("ab_fcw", 26'($urandom()), 2'($urandom()), 4, -1, 0, t0, td, np);
        ab = int'($urandom_range(9, 8 + SETTLE));
        run_seq("ab_settle", 26'($urandom()), 2'($urandom()), ab, -1, 0, t0, td, np);

        // Slow target, random lock patterns.
        pat.delete();
        for (int i = 0; i < 40; i++) pat.push_back($urandom_range(0, 3) != 0);
        run_seq("slow", 26'($urandom()), 2'($urandom()), -1, -1, 3, t0, td, np);
        for (int r = 0; r < 2; r++) begin
            pat.delete();
            for (int i = 0; i < 40; i++) pat.push_back($urandom_range(0, 2) != 0);
            run_seq($sformatf("rnd%0d", r), 26'($urandom()), 2'($urandom()), -1, -1,
                    int'($urandom_range(0, 2)), t0, td, np);
        end

        // Reset while polling.
        pat.delete(); lock_dflt = 1'b0; extra_dly = 0;
        fcw = 26'($urandom()); mode = 2'($urandom()); start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        while (cyc < t0 + 280) tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_locked", 64'(locked), 64'd0);
        chk("arst_timeout", 64'(timeout), 64'd0);
        chk("arst_valid", 64'(bus.m_valid), 64'd0);
        chk("arst_addr", 64'(bus.m_address), 64'd0);
        chk("arst_wdata", 64'(bus.m_wdata), 64'd0);
        chk("arst_wstrb", 64'(bus.m_wstrb), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        lock_dflt = 1'b1;
        run_seq("post_rst", 26'($urandom()), 2'($urandom()), -1, -1, 0, t0, td, np);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
